mult_err_acc: RTL and testbench

- Downstream error-statistics stage for the 16x16 approximate radix-4 Booth multiplier wrapper.
- Consumes operand pairs and the registered approximate product, recomputes the exact signed product, and accumulates error metrics over a fixed batch:
  - sum of absolute error
  - maximum absolute error
  - count of erroneous products
- Used for on-chip accuracy characterisation (MED/ER estimation) of approximate multiplier variants.

---
 rtl/mult_err_acc.sv | 136 +++++++++++++
 tb/tb_mult_err_acc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_err_acc.sv
// mult_err_acc: accuracy statistics for an approximate 16x16 signed multiplier.
// Stage 1 captures the exact product. Stage 2 folds |exact - approx| into the batch metrics.

module mult_err_absdiff (
    input  logic [31:0] exact,
    input  logic [31:0] approx,
    output logic [32:0] abs_err
);
    logic [32:0] diff;

    // One guard bit is enough: |diff| <= 2^32 - 1, so negation cannot overflow.
    assign diff    = {exact[31], exact} - {approx[31], approx};
    assign abs_err = diff[32] ? (~diff + 33'd1) : diff;
endmodule

module mult_err_acc #(
    parameter int N_SAMPLES = 1024,
    parameter int CNT_W     = 17,
    parameter int ACC_W     = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       x,
    input  logic [15:0]       y,
    input  logic [31:0]       p_approx,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  sum_abs_err,
    output logic [32:0]       max_abs_err,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  sample_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    typedef struct packed {
        logic [31:0] exact;
        logic [31:0] approx;
    } s1_t;

    logic [1:0]        state;
    logic [CNT_W-1:0]  acc_cnt;
    logic              accept;
    logic              clear;
    logic              s1_vld;
    s1_t               s1;
    logic signed [31:0] xs;
    logic signed [31:0] ys;
    logic signed [31:0] prod;
    logic [32:0]       abs_err;
    logic [ACC_W:0]    sum_ext;

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign accept   = in_ready && in_valid;
    assign clear    = start && ((state == IDLE) || (state == DONE));

    assign xs   = 32'($signed(x));
    assign ys   = 32'($signed(y));
    assign prod = xs * ys;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        acc_cnt <= '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt == LAST) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Stage 2 has no valid of its own: it retires on the edge after stage 1.
                    if (!s1_vld) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else begin
            s1_vld <= accept && !clear;
            if (accept) begin
                s1.exact  <= prod;
                s1.approx <= p_approx;
            end
        end
    end

    mult_err_absdiff u_absdiff (
        .exact   (s1.exact),
        .approx  (s1.approx),
        .abs_err (abs_err)
    );

    assign sum_ext = {1'b0, sum_abs_err} + (ACC_W + 1)'(abs_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
            err_count    <= '0;
            sample_count <= '0;
        end else if (clear) begin
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
            err_count    <= '0;
            sample_count <= '0;
        end else if (s1_vld) begin
            sum_abs_err  <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (abs_err > max_abs_err) max_abs_err <= abs_err;
            err_count    <= err_count + CNT_W'(abs_err != 33'd0);
            sample_count <= sample_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_mult_err_acc.sv
// Bench for mult_err_acc: two instances (48b and 33b accumulators) on shared stimulus,
// compared against a sample-list reference model every cycle.
module tb_mult_err_acc;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic signed [15:0] x = '0;
    logic signed [15:0] y = '0;
    logic signed [31:0] p_approx = '0;

    logic        rdy_a, busy_a, done_a;
    logic [47:0] sum_a;
    logic [32:0] max_a;
    logic [16:0] ec_a, sc_a;
    logic        rdy_b, busy_b, done_b;
    logic [32:0] sum_b;
    logic [32:0] max_b;
    logic [16:0] ec_b, sc_b;

    always #5 clk = ~clk;

    mult_err_acc #(.N_SAMPLES(N), .CNT_W(17), .ACC_W(48)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
        .x(x), .y(y), .p_approx(p_approx), .busy(busy_a), .done(done_a),
        .sum_abs_err(sum_a), .max_abs_err(max_a), .err_count(ec_a), .sample_count(sc_a));

    mult_err_acc #(.N_SAMPLES(N), .CNT_W(17), .ACC_W(33)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
        .x(x), .y(y), .p_approx(p_approx), .busy(busy_b), .done(done_b),
        .sum_abs_err(sum_b), .max_abs_err(max_b), .err_count(ec_b), .sample_count(sc_b));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: list of (exact - approx) for every accepted sample of the batch.
    longint m_q[$];
    bit     m_active, m_running, m_ended;
    int     m_nacc, m_since;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] mulx(input logic signed [15:0] a, input logic signed [15:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    task automatic exp_stats(input int acc_w, output logic [63:0] s, output logic [63:0] mx,
                             output logic [63:0] ec, output logic [63:0] sc);
        longint sum, mxv, e, ad, lim;
        sum = 0; mxv = 0; e = 0;
        foreach (m_q[i]) begin
            ad = (m_q[i] < 0) ? -m_q[i] : m_q[i];
            sum += ad;
            if (ad > mxv) mxv = ad;
            if (ad != 0) e++;
        end
        lim = (64'sd1 <<< acc_w) - 1;
        s  = (sum > lim) ? lim : sum;
        mx = mxv;
        ec = e;
        sc = m_q.size();
    endtask

    function automatic bit done_exp();
        return m_ended && (m_since >= 2);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 0; m_running = 0; m_ended = 0; m_nacc = 0; m_since = 0;
    endtask

    task automatic check_all();
        logic [63:0] s, mx, ec, sc;
        bit d;
        d = done_exp();
        chk("in_ready", {63'd0, rdy_a}, {63'd0, m_running});
        chk("busy", {63'd0, busy_a}, {63'd0, m_active && !d});
        chk("done", {63'd0, done_a}, {63'd0, d});
        chk("done_sat", {63'd0, done_b}, {63'd0, d});
        if (!m_active || d) begin
            exp_stats(48, s, mx, ec, sc);
            chk("sum48", 64'(sum_a), s);
            chk("max48", 64'(max_a), mx);
            chk("err48", 64'(ec_a), ec);
            chk("cnt48", 64'(sc_a), sc);
            exp_stats(33, s, mx, ec, sc);
            chk("sum33", 64'(sum_b), s);
            chk("max33", 64'(max_b), mx);
            chk("err33", 64'(ec_b), ec);
            chk("cnt33", 64'(sc_b), sc);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check just after it.
    task automatic cyc(input bit v, input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic signed [31:0] p, input bit st);
        bit idle_pre;
        in_valid = v; x = a; y = b; p_approx = p; start = st;
        @(posedge clk);
        idle_pre = !(m_active && !done_exp());
        if (st && idle_pre) begin
            m_q.delete();
            m_active = 1; m_running = 1; m_ended = 0; m_nacc = 0; m_since = 0;
        end else begin
            if (m_ended) m_since++;
            if (m_running && v) begin
                m_q.push_back(longint'(a) * longint'(b) - longint'(p));
                m_nacc++;
                if (m_nacc == N) begin
                    m_running = 0; m_ended = 1; m_since = 0;
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 0; start = 0;
        model_reset();
        #3;
        check_all();
        #4;
        rst_n = 1'b1;
    endtask

    task automatic run_batch(input int kind);
        logic signed [15:0] a, b;
        logic signed [31:0] p;
        for (int i = 0; i < N; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            case (kind)
                0: if (i == 0) begin a = 16'sd1234; b = -16'sd77; end
                2: begin
                    if (i == 2) begin a = -16'sd32768; b = -16'sd32768; end
                    if (i == 9) begin a = -16'sd1; b = 16'sd1; end
                end
                3: begin a = -16'sd32768; b = -16'sd32768; end
                default: ;
            endcase
            p = mulx(a, b);
            case (kind)
                1: begin
                    if (i == 3)  p = p + 32'sd5;
                    if (i == 8)  p = p - 32'sd7;
                    if (i == 12) p = p + 32'sd1;
                end
                2: begin
                    if (i == 2) p = 32'sh80000000;
                    if (i == 9) p = 32'sd0;
                end
                3: p = 32'sh80000000;
                default: ;
            endcase
            cyc(1, a, b, p, 0);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        logic signed [15:0] a, b;
        logic signed [31:0] p;
        int guard;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Exact batch; start arrives with in_valid high from IDLE, sample not taken.
        cyc(1, 16'sd5, 16'sd5, 32'sd99, 1);
        run_batch(0);
        chk("exact_sum", 64'(sum_a), 64'd0);
        chk("exact_cnt", 64'(sc_a), 64'd16);

        cyc(0, 0, 0, 0, 1);
        run_batch(1);
        chk("known_sum", 64'(sum_a), 64'd13);
        chk("known_max", 64'(max_a), 64'd7);
        chk("known_err", 64'(ec_a), 64'd3);

        cyc(0, 0, 0, 0, 1);
        run_batch(2);
        chk("ext_max", 64'(max_a), 64'h0_C000_0000);
        chk("ext_sum", 64'(sum_a), 64'h0_C000_0001);

        cyc(0, 0, 0, 0, 1);
        run_batch(3);
        chk("sat_sum33", 64'(sum_b), 64'h1_FFFF_FFFF);
        chk("sat_sum48", 64'(sum_a), 64'hC_0000_0000);
        chk("sat_err", 64'(ec_b), 64'd16);

        // Flow control: random gaps and stray starts in RUN, start in DRAIN, in_valid held after N.
        cyc(0, 0, 0, 0, 1);
        guard = 0;
        while (m_nacc < N && guard < 500) begin
            a = 16'($urandom); b = 16'($urandom);
            p = ($urandom_range(0, 2) == 0) ? 32'($urandom) : mulx(a, b) + 32'($urandom_range(0, 3));
            cyc(bit'($urandom_range(0, 1)), a, b, p, $urandom_range(0, 5) == 0);
            guard++;
        end
        chk("flow_bound", 64'(m_nacc), 64'(N));
        cyc(1, 16'sd3, 16'sd3, 32'sd0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 16'sd3, 16'sd3, 32'sd0, 0);
        chk("flow_cnt", 64'(sc_a), 64'd16);

        // Reset mid-run after five samples, then a fresh exact batch.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 16'sd7, -16'sd9, 32'sd0, 0);
        @(posedge clk); #1;
        do_reset();
        chk("rst_cnt", 64'(sc_a), 64'd0);
        cyc(0, 0, 0, 0, 1);
        run_batch(0);
        chk("post_rst_cnt", 64'(sc_a), 64'd16);
        chk("post_rst_sum", 64'(sum_a), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
